// File: rtl/pyrxaclbufq_pkg.sv
// pyrxaclbufq_pkg
// Shared constants and helpers for the N-bank RX ACL payload buffer queue.
// The *_DEF values are the default configuration of the top; BPW, BUFW and CAP
// are derived from that default configuration.
// f_endaddr converts a byte length into the index of the last word holding
// payload bytes, rounding a partial trailing word up.

package pyrxaclbufq_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 8;
  localparam int NBUF_DEF = 4;
  localparam int LENW_DEF = 10;

  localparam int BPW  = DW_DEF / 8;
  localparam int BUFW = $clog2(NBUF_DEF);
  localparam int CAP  = BPW * (2 ** AW_DEF);

  // sh = log2(bytes per word). Only meaningful for len != 0.
  function automatic logic [31:0] f_endaddr(input logic [31:0] len, input int sh);
    logic [31:0] mask;
    logic [31:0] words;
    mask  = (32'd1 << sh) - 32'd1;
    words = (len >> sh) + (((len & mask) != 32'd0) ? 32'd1 : 32'd0);
    return words - 32'd1;
  endfunction

endpackage

// File: rtl/pyrxbuf_mem_2p.sv
// pyrxbuf_mem_2p
// Simple dual-port RAM, one synchronous write port and one synchronous read
// port with 1-cycle latency. rdata holds its value when re is low.
// Ports:
//   clk_6M            clock
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port (rdata valid the cycle after re)

module pyrxbuf_mem_2p #(
  parameter int DW    = 32,
  parameter int ADDRW = 10
) (
  input  logic             clk_6M,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [ADDRW-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [2**ADDRW];

  always_ff @(posedge clk_6M) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pyrxaclbufq.sv
// pyrxaclbufq
// N-bank receive ACL payload buffer queue. The link controller fills the bank
// at wptr; a good packet at the slot boundary commits it. The bsm reads banks
// in commit order from rptr; consuming the last word of a bank releases it.
// Ports:
//   clk_6M, rstz                        clock, synchronous active-low reset
//   m_tslot_p, s_tslot_p, regi_isMaster slot pulse select
//   pk_encode, hecgood, crcgood         commit qualifiers
//   dec_pylenByte                       decoded payload length (bytes)
//   lnctrl_cs/we/addr/din               write port into current write bank
//   bsm_cs/addr/valid_p, bsm_dout       read port on head bank, 1-cycle latency
//   bsm_pylenByte                       length of head bank (0 when empty)
//   regi_aclrxflush, regi_ovfclr        flush / overflow clear pulses
//   regi_aclrxbufempty/full/cnt/ovf     status

module pyrxaclbufq
  import pyrxaclbufq_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NBUF = NBUF_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic                    clk_6M,
  input  logic                    rstz,
  input  logic                    m_tslot_p,
  input  logic                    s_tslot_p,
  input  logic                    regi_isMaster,
  input  logic                    pk_encode,
  input  logic                    hecgood,
  input  logic                    crcgood,
  input  logic [LENW-1:0]         dec_pylenByte,
  input  logic                    lnctrl_cs,
  input  logic                    lnctrl_we,
  input  logic [AW-1:0]           lnctrl_addr,
  input  logic [DW-1:0]           lnctrl_din,
  input  logic                    bsm_cs,
  input  logic [AW-1:0]           bsm_addr,
  input  logic                    bsm_valid_p,
  input  logic                    regi_aclrxflush,
  input  logic                    regi_ovfclr,
  output logic [DW-1:0]           bsm_dout,
  output logic [LENW-1:0]         bsm_pylenByte,
  output logic                    regi_aclrxbufempty,
  output logic                    regi_aclrxbuffull,
  output logic [$clog2(NBUF):0]   regi_aclrxbufcnt,
  output logic                    regi_aclrxovf
);

  localparam int PTRW = $clog2(NBUF);
  localparam int CNTW = PTRW + 1;
  localparam int BPWL = $clog2(DW / 8);
  localparam logic [31:0] CAP_B = 32'((DW / 8) * (2 ** AW));

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [LENW-1:0] len_q [NBUF];
  logic            dout_zero_q;

  logic            empty, full;
  logic            ms_tslot_p, commit, release_p, accept, drop;
  logic [LENW-1:0] len_sat;
  logic [31:0]     end_addr;
  logic [DW-1:0]   ram_q;

  assign empty = (cnt_q == CNTW'(0));
  assign full  = (cnt_q == CNTW'(NBUF));

  assign ms_tslot_p = regi_isMaster ? m_tslot_p : s_tslot_p;
  assign commit     = ms_tslot_p & ~pk_encode & hecgood & crcgood & (dec_pylenByte != '0);

  // When CAP_B exceeds the LENW range the saturating branch is unreachable.
  assign len_sat = (32'(dec_pylenByte) > CAP_B) ? LENW'(CAP_B) : dec_pylenByte;

  assign end_addr  = f_endaddr(32'(len_q[rptr_q]), BPWL);
  assign release_p = bsm_valid_p & ~empty & (32'(bsm_addr) >= end_addr);

  // A release in the same cycle frees a slot, so a commit is accepted even when full.
  assign accept = commit & (~full | release_p) & ~regi_aclrxflush;
  assign drop   = commit & full & ~release_p & ~regi_aclrxflush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (release_p) rptr_d = rptr_q + PTRW'(1);
    if (accept)    wptr_d = wptr_q + PTRW'(1);
    if (accept && !release_p)      cnt_d = cnt_q + CNTW'(1);
    else if (release_p && !accept) cnt_d = cnt_q - CNTW'(1);
    if (regi_ovfclr) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
    if (regi_aclrxflush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      dout_zero_q <= 1'b1;
      for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      if (accept) len_q[wptr_q] <= len_sat;
      // RAM output register has no reset; mask it after reset and for empty reads.
      if (bsm_cs) dout_zero_q <= empty;
    end
  end

  pyrxbuf_mem_2p #(
    .DW    (DW),
    .ADDRW (PTRW + AW)
  ) u_mem (
    .clk_6M (clk_6M),
    .we     (lnctrl_cs & lnctrl_we & ~full),
    .waddr  ({wptr_q, lnctrl_addr}),
    .wdata  (lnctrl_din),
    .re     (bsm_cs & ~empty),
    .raddr  ({rptr_q, bsm_addr}),
    .rdata  (ram_q)
  );

  assign bsm_dout           = dout_zero_q ? '0 : ram_q;
  assign bsm_pylenByte      = empty ? '0 : len_q[rptr_q];
  assign regi_aclrxbufempty = empty;
  assign regi_aclrxbuffull  = full;
  assign regi_aclrxbufcnt   = cnt_q;
  assign regi_aclrxovf      = ovf_q;

endmodule

// File: tb/tb_pyrxaclbufq.sv
module tb_pyrxaclbufq;
  import pyrxaclbufq_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int NBUF = 4;
  localparam int LENW = 11;
  localparam int DEPTH = 2 ** AW;

  logic            clk_6M = 1'b0;
  logic            rstz;
  logic            m_tslot_p, s_tslot_p, regi_isMaster;
  logic            pk_encode, hecgood, crcgood;
  logic [LENW-1:0] dec_pylenByte;
  logic            lnctrl_cs, lnctrl_we;
  logic [AW-1:0]   lnctrl_addr;
  logic [DW-1:0]   lnctrl_din;
  logic            bsm_cs;
  logic [AW-1:0]   bsm_addr;
  logic            bsm_valid_p;
  logic            regi_aclrxflush, regi_ovfclr;
  logic [DW-1:0]   bsm_dout;
  logic [LENW-1:0] bsm_pylenByte;
  logic            regi_aclrxbufempty, regi_aclrxbuffull, regi_aclrxovf;
  logic [BUFW:0]   regi_aclrxbufcnt;

  pyrxaclbufq #(.DW(DW), .AW(AW), .NBUF(NBUF), .LENW(LENW)) dut (
    .clk_6M(clk_6M), .rstz(rstz),
    .m_tslot_p(m_tslot_p), .s_tslot_p(s_tslot_p), .regi_isMaster(regi_isMaster),
    .pk_encode(pk_encode), .hecgood(hecgood), .crcgood(crcgood),
    .dec_pylenByte(dec_pylenByte),
    .lnctrl_cs(lnctrl_cs), .lnctrl_we(lnctrl_we), .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din),
    .bsm_cs(bsm_cs), .bsm_addr(bsm_addr), .bsm_valid_p(bsm_valid_p),
    .regi_aclrxflush(regi_aclrxflush), .regi_ovfclr(regi_ovfclr),
    .bsm_dout(bsm_dout), .bsm_pylenByte(bsm_pylenByte),
    .regi_aclrxbufempty(regi_aclrxbufempty), .regi_aclrxbuffull(regi_aclrxbuffull),
    .regi_aclrxbufcnt(regi_aclrxbufcnt), .regi_aclrxovf(regi_aclrxovf)
  );

  always #5 clk_6M = ~clk_6M;

  // reference model
  logic [31:0] m_mem [NBUF*DEPTH];
  int          m_len [NBUF];
  int          m_wptr, m_rptr, m_cnt;
  logic        m_ovf;
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rstz = 1'b1;
    m_tslot_p = 1'b0; s_tslot_p = 1'b0;
    pk_encode = 1'b0; hecgood = 1'b0; crcgood = 1'b0;
    dec_pylenByte = '0;
    lnctrl_cs = 1'b0; lnctrl_we = 1'b0; lnctrl_addr = '0; lnctrl_din = '0;
    bsm_cs = 1'b0; bsm_addr = '0; bsm_valid_p = 1'b0;
    regi_aclrxflush = 1'b0; regi_ovfclr = 1'b0;
  endtask

  // Applies the inputs currently driven for one clock, advancing the model
  // from the same inputs, then checks read data and status.
  task automatic step();
    bit   m_empty, m_full, ms, com, rel, acc, drop, rd;
    int   ea, lsat;
    logic [31:0] exp_d;
    m_empty = (m_cnt == 0);
    m_full  = (m_cnt == NBUF);
    rd = 1'b0;
    if (!rstz) begin
      sb.push_back(32'h0);
      rd = 1'b1;
      m_wptr = 0; m_rptr = 0; m_cnt = 0; m_ovf = 1'b0;
      for (int i = 0; i < NBUF; i++) m_len[i] = 0;
    end else begin
      ms  = regi_isMaster ? m_tslot_p : s_tslot_p;
      com = ms && !pk_encode && hecgood && crcgood && (dec_pylenByte != 0);
      ea  = (m_len[m_rptr] + BPW - 1) / BPW - 1;
      rel = bsm_valid_p && !m_empty && (int'(bsm_addr) >= ea);
      if (bsm_cs) begin
        sb.push_back(m_empty ? 32'h0 : m_mem[m_rptr*DEPTH + int'(bsm_addr)]);
        rd = 1'b1;
      end
      if (lnctrl_cs && lnctrl_we && !m_full) m_mem[m_wptr*DEPTH + int'(lnctrl_addr)] = lnctrl_din;
      drop = com && m_full && !rel && !regi_aclrxflush;
      if (regi_aclrxflush) begin
        m_wptr = 0; m_rptr = 0; m_cnt = 0;
      end else begin
        acc = com && (!m_full || rel);
        if (acc) begin
          lsat = (int'(dec_pylenByte) > CAP) ? CAP : int'(dec_pylenByte);
          m_len[m_wptr] = lsat;
          m_wptr = (m_wptr + 1) % NBUF;
          m_cnt++;
        end
        if (rel) begin
          m_rptr = (m_rptr + 1) % NBUF;
          m_cnt--;
        end
      end
      if (regi_ovfclr) m_ovf = 1'b0;
      if (drop)        m_ovf = 1'b1;
    end
    @(negedge clk_6M);
    clear_inputs();
    if (rd) begin
      exp_d = sb.pop_front();
      chk("bsm_dout", bsm_dout, exp_d);
    end
    chk("cnt",   32'(regi_aclrxbufcnt), 32'(m_cnt));
    chk("empty", 32'(regi_aclrxbufempty), 32'(m_cnt == 0));
    chk("full",  32'(regi_aclrxbuffull), 32'(m_cnt == NBUF));
    chk("ovf",   32'(regi_aclrxovf), 32'(m_ovf));
    chk("pylen", 32'(bsm_pylenByte), (m_cnt == 0) ? 32'h0 : 32'(m_len[m_rptr]));
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = AW'(a); lnctrl_din = d;
    step();
  endtask

  task automatic rd(input int a, input bit v);
    bsm_cs = 1'b1; bsm_addr = AW'(a); bsm_valid_p = v;
    step();
  endtask

  task automatic commit(input int len, input bit hec, input bit crc, input bit pk, input bit use_s);
    if (use_s) s_tslot_p = 1'b1; else m_tslot_p = 1'b1;
    hecgood = hec; crcgood = crc; pk_encode = pk;
    dec_pylenByte = LENW'(len);
    step();
  endtask

  initial begin
    clear_inputs();
    regi_isMaster = 1'b1;
    m_wptr = 0; m_rptr = 0; m_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < NBUF; i++) m_len[i] = 0;

    rstz = 1'b0;
    step();

    // three commits, third saturates to CAP
    for (int a = 0; a < 5; a++) wr(a, 32'hA5A5_0000 + 32'(a));
    commit(17, 1, 1, 0, 0);
    wr(0, 32'hA5A5_0100);
    commit(4, 1, 1, 0, 0);
    wr(0, 32'hA5A5_0200);
    wr(255, 32'hA5A5_02FF);
    commit(1100, 1, 1, 0, 0);

    // read head bank, release only on its last word (addr 4)
    for (int a = 0; a < 5; a++) rd(a, a == 4);
    // head length 4 -> single word, addr 0 releases
    rd(0, 1);

    // fill to full, then overflow
    wr(0, 32'hA5A5_0300); commit(8, 1, 1, 0, 0);
    wr(0, 32'hA5A5_0400); commit(8, 1, 1, 0, 0);
    wr(0, 32'hA5A5_0500); commit(8, 1, 1, 0, 0);
    wr(0, 32'hDEAD_BEEF);
    commit(20, 1, 1, 0, 0);
    rd(0, 0);
    regi_ovfclr = 1'b1;
    step();

    // commit and release in the same cycle while full
    bsm_cs = 1'b1; bsm_addr = AW'(255); bsm_valid_p = 1'b1;
    m_tslot_p = 1'b1; hecgood = 1'b1; crcgood = 1'b1; dec_pylenByte = LENW'(12);
    step();

    regi_aclrxflush = 1'b1;
    step();

    // disqualified commits
    commit(16, 0, 1, 0, 0);
    commit(16, 1, 0, 0, 0);
    commit(16, 1, 1, 1, 0);
    commit(0,  1, 1, 0, 0);
    commit(16, 1, 1, 0, 1);
    regi_isMaster = 1'b0;
    commit(16, 1, 1, 0, 0);
    commit(16, 1, 1, 0, 1);
    regi_isMaster = 1'b1;

    regi_aclrxflush = 1'b1;
    step();

    // two banks of pattern, flush mid-read
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) wr(a, 32'hA5A5_0000 + 32'(a));
      commit(16, 1, 1, 0, 0);
    end
    rd(0, 0);
    rd(1, 0);
    bsm_cs = 1'b1; bsm_addr = AW'(2); regi_aclrxflush = 1'b1;
    step();
    rd(0, 0);

    // reset mid-read
    commit(16, 1, 1, 0, 0);
    rd(1, 0);
    rstz = 1'b0; bsm_cs = 1'b1; bsm_addr = AW'(2);
    step();
    rd(3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
